// File: rtl/mux_rr_stream.sv
// N-channel valid/ready stream mux with a registered output stage.
// Static select (mode 0) or round-robin arbitration (mode 1); out_ch tags each word.
module mux_rr_lane #(
    parameter int IDX   = 0,
    parameter int log2N = 2
) (
    input  logic             load_en,
    input  logic             rst_n,
    input  logic             grant_vld,
    input  logic [log2N-1:0] grant,
    output logic             ready
);
    assign ready = load_en & rst_n & grant_vld & (grant == log2N'(IDX));
endmodule

module mux_rr_stream #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int log2N = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [log2N-1:0] sel,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [log2N-1:0] out_ch
);
    logic [log2N-1:0] ptr;
    logic [log2N-1:0] grant;
    logic             grant_vld;
    logic             load_en;
    logic             xfer;
    int               idx;

    assign load_en = !out_valid | out_ready;

    // Mode 1 scans from ptr+1 downward-overwriting so the nearest valid channel wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        if (!mode) begin
            for (int k = 0; k < N; k++) begin
                if (sel == log2N'(k) && in_valid[k]) begin
                    grant     = log2N'(k);
                    grant_vld = 1'b1;
                end
            end
        end else begin
            for (int i = N; i >= 1; i--) begin
                idx = int'(ptr) + i;
                if (idx >= N) idx = idx - N;
                if (in_valid[idx]) begin
                    grant     = log2N'(idx);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        mux_rr_lane #(.IDX(k), .log2N(log2N)) u_lane (
            .load_en   (load_en),
            .rst_n     (rst_n),
            .grant_vld (grant_vld),
            .grant     (grant),
            .ready     (in_ready[k])
        );
    end

    // grant_vld already implies in_valid of the granted channel.
    assign xfer = grant_vld & load_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= log2N'(N-1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant)*W +: W];
            out_ch    <= grant;
            if (mode) ptr <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
